// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and length-field helper for the SHA-256 front end.
package sha256_pkg;

   localparam int INWIDTH         = 32;
   localparam int BLOCKWIDTH      = 512;
   localparam int LENWIDTH        = 64;
   localparam int WORDS_PER_BLOCK = 16;
   localparam int CNTWIDTH        = 61;

   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      EMIT  = 2'd1,
      PAD_A = 2'd2,
      PAD_B = 2'd3
   } padder_state_e;

   // Message bit length as the two trailing block words, high word first.
   function automatic logic [LENWIDTH-1:0] length_words(input logic [CNTWIDTH-1:0] byte_cnt);
      return {byte_cnt, 3'b000};
   endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a final message word to its first k bytes and inserts the 0x80 pad byte at byte k.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  k,
   input  logic        last,
   output logic [31:0] padded
);

   always_comb begin
      padded = word;
      if (last) begin
         // k==4 leaves the word whole; the pad byte then belongs to the next word.
         case (k)
            3'd0:    padded = {PAD_BYTE, 24'h000000};
            3'd1:    padded = {word[31:24], PAD_BYTE, 16'h0000};
            3'd2:    padded = {word[31:16], PAD_BYTE, 8'h00};
            3'd3:    padded = {word[31:8], PAD_BYTE};
            default: padded = word;
         endcase
      end
   end

endmodule

// File: rtl/sha256_message_padder.sv
// Packs 32-bit message words into 512-bit blocks with FIPS 180-4 padding and length.
module sha256_message_padder
   import sha256_pkg::*;
#(
   parameter int INWIDTH    = sha256_pkg::INWIDTH,
   parameter int BLOCKWIDTH = sha256_pkg::BLOCKWIDTH,
   parameter int LENWIDTH   = sha256_pkg::LENWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INWIDTH-1:0]    in_data,
   input  logic [2:0]            in_bytes,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BLOCKWIDTH-1:0] out_block,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   padder_state_e state, state_next;

   // Word i of the block lives at blk[15-i] so word 0 lands in the top bits.
   logic [WORDS_PER_BLOCK-1:0][31:0] blk;
   logic [3:0]                       w;
   logic [CNTWIDTH-1:0]              byte_cnt;
   logic                             last_q;
   logic                             wrap_marker;
   logic                             ready_en;

   logic [2:0]          k;
   logic [31:0]         padded;
   logic [4:0]          filled;
   logic [CNTWIDTH-1:0] cnt_next;
   logic [LENWIDTH-1:0] len_next;
   logic [LENWIDTH-1:0] len_now;
   logic                in_fire;
   logic                out_fire;

   assign k        = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
   assign filled   = {1'b0, w} + ((k == 3'd4) ? 5'd2 : 5'd1);
   assign cnt_next = byte_cnt + (in_last ? {{(CNTWIDTH-3){1'b0}}, k} : {{(CNTWIDTH-3){1'b0}}, 3'd4});
   assign len_next = length_words(cnt_next);
   assign len_now  = length_words(byte_cnt);

   assign in_ready  = ready_en && (state == ACCUM);
   assign out_valid = (state != ACCUM);
   assign out_last  = last_q;
   assign out_block = blk;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   sha256_pad_word u_pad_word (
      .word   (in_data),
      .k      (k),
      .last   (in_last),
      .padded (padded)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ACCUM;
         ready_en <= 1'b0;
      end else begin
         state    <= state_next;
         ready_en <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCUM: begin
            if (in_fire) begin
               if (in_last)         state_next = PAD_A;
               else if (w == 4'd15) state_next = EMIT;
            end
         end
         EMIT:  if (out_fire) state_next = ACCUM;
         PAD_A: if (out_fire) state_next = last_q ? ACCUM : PAD_B;
         PAD_B: if (out_fire) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk         <= '0;
         w           <= '0;
         byte_cnt    <= '0;
         last_q      <= 1'b0;
         wrap_marker <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_fire) begin
                  blk[4'd15 - w] <= padded;
                  byte_cnt       <= cnt_next;
                  if (in_last) begin
                     if (k == 3'd4 && w != 4'd15)
                        blk[4'd14 - w] <= {PAD_BYTE, 24'h000000};
                     // Words past the tail are already zero from the last clear.
                     if (filled <= 5'd14) begin
                        blk[1] <= len_next[63:32];
                        blk[0] <= len_next[31:0];
                        last_q <= 1'b1;
                     end else begin
                        last_q <= 1'b0;
                     end
                     wrap_marker <= (filled == 5'd17);
                  end else begin
                     last_q <= 1'b0;
                     w      <= w + 4'd1;
                  end
               end
            end
            EMIT: begin
               if (out_fire) begin
                  blk <= '0;
                  w   <= '0;
               end
            end
            PAD_A: begin
               if (out_fire) begin
                  blk <= '0;
                  if (last_q) begin
                     w        <= '0;
                     byte_cnt <= '0;
                     last_q   <= 1'b0;
                  end else begin
                     // Length-only block; carries the pad byte when data ended exactly on a block.
                     blk[15] <= wrap_marker ? {PAD_BYTE, 24'h000000} : 32'h0;
                     blk[1]  <= len_now[63:32];
                     blk[0]  <= len_now[31:0];
                     last_q  <= 1'b1;
                  end
               end
            end
            PAD_B: begin
               if (out_fire) begin
                  blk      <= '0;
                  w        <= '0;
                  byte_cnt <= '0;
                  last_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
